mc_controller: RTL
==================

# mc_controller

Multi-cycle successor to the single-cycle `controller`: a finite-state control unit for the MIPS datapath that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the same datapath select fields as `controller`, with the same encodings, plus write strobes for the PC, IR and memories. Instruction and data memory latency are parametrised wait-state counts. Unsupported opcodes raise an `illegal` flag instead of producing undefined controls.

## Interface
- `IMEM_WAIT`, default 0: extra FETCH cycles, range 0..15.
- `DMEM_WAIT`, default 0: extra MEM cycles, range 0..15.
- `CNT_W`, default 4: wait-counter width. Both WAIT parameters must be ≤ 2^CNT_W−1.

Clocking and reset are one clock, with asynchronous active-low reset.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]. Valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `NFlag`  in  32  ALU flags. Bit1 = equal/zero, bit0 = signed overflow.
- `RegDst`  out  2  00 rt, 01 rd, 10 $31.
- `ALUSrc`  out  1  0 = register B, 1 = extended immediate.
- `Mem2Reg`  out  2  00 ALU, 01 memory, 10 PC register (holds PC+4 after FETCH).
- `EXTOp`  out  2  00 zero-extend, 01 sign-extend, 10 LUI (imm<<16).
- `ALUOp`  out  3  000 add, 001 sub, 011 or, 100 slt, 101 pass A.
- `NPCSel`  out  2  00 PC+4, 01 branch, 10 jump, 11 register (jr).
- `FlagOp`  out  1  1 = suppress RegWr on overflow (ADDI).
- `RegWr`, `MemWr`, `MemRd`, `PCWr`, `IRWr`  out  1 each  write/read strobes.
- `illegal`  out  1  one-cycle pulse, unsupported instruction.
- `instr_done`  out  1  one-cycle pulse in the last cycle of each instruction.
- `state`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

## Operation
**Decode.** The decoded instruction class comes from `opcode`/`funct` (standard MIPS encodings):
- Special functs: ADDU, SUBU, SLT, JR.
- Opcodes: ORI, LW, SW, BEQ, LUI, J, ADDI, ADDIU, JAL.

**Select fields** (`RegDst`, `ALUSrc`, `Mem2Reg`, `EXTOp`, `ALUOp`, `FlagOp`):
- Held constant for the instruction from DECODE through its last state.
- Fields irrelevant to the instruction are driven 0, never z/x.
- In FETCH, all select fields are 0.

**Per-class values:**
- ADDU/SUBU/SLT: RegDst=01, ALUOp=000/001/100.
- ORI: ALUSrc=1, EXTOp=00, ALUOp=011.
- LUI: ALUSrc=1, EXTOp=10, ALUOp=011.
- ADDI: ALUSrc=1, EXTOp=01, ALUOp=000, FlagOp=1.
- ADDIU: as ADDI but FlagOp=0.
- LW/SW: ALUSrc=1, EXTOp=01, ALUOp=000. LW additionally Mem2Reg=01.
- BEQ: ALUOp=001.
- JR: ALUOp=101.
- J: no select fields set.
- JAL: RegDst=10, Mem2Reg=10, ALUOp=101.

**State transitions:**
- FETCH
  - Lasts 1+IMEM_WAIT cycles. `MemRd`=1 throughout.
  - In the last cycle: `IRWr`=1, `PCWr`=1 with NPCSel=00. Then → DECODE.
- DECODE
  - J: `PCWr`=1 with NPCSel=10, then → FETCH.
  - JAL: `PCWr`=1 with NPCSel=10, plus `RegWr`=1, then → FETCH.
  - Illegal instruction: `illegal`=1, no strobes, then → FETCH (PC already advanced).
  - Otherwise → EXEC.
- EXEC
  - BEQ: `PCWr`=NFlag[1] with NPCSel=01, then → FETCH.
  - JR: `PCWr`=1 with NPCSel=11, then → FETCH.
  - LW/SW → MEM.
  - Others → WB.
- MEM
  - Lasts 1+DMEM_WAIT cycles.
  - LW: `MemRd`=1 throughout, then → WB.
  - SW: `MemWr`=1 throughout, then → FETCH.
- WB
  - `RegWr` = ~(FlagOp & NFlag[0]), then → FETCH.

**Wait counter:**
- Loads 0 on entry to FETCH or MEM, increments each cycle.
- The state exits when count == WAIT.
- With WAIT=0 the state lasts exactly one cycle.

**Pulses:**
- `instr_done`=1 in the final cycle of every instruction, including illegal instructions.
- Never 1 in FETCH.

## Timing
- Reset
  - While `rst_n`=0: state=FETCH, counter=0, all strobes/pulses 0, all selects 0.
  - Asserting reset mid-instruction aborts it immediately with no further strobes.
  - First FETCH cycle begins at the first clock edge after `rst_n` rises.
- Outputs are combinational from the state register, the counter, `opcode`/`funct` and `NFlag`.
- State changes on the rising edge of `clk`.
- Cycles per instruction, with W = IMEM_WAIT and D = DMEM_WAIT:
  - J/JAL/illegal: 2+W.
  - BEQ, JR: 3+W.
  - R-type/immediate ALU: 4+W.
  - SW: 4+W+D.
  - LW: 5+W+D.
- At most one of `PCWr`/`IRWr` pairs differs per cycle; `RegWr` and `MemWr` are never both 1.

## Test plan
- Reset then ADDU (000000/100001), waits 0: state 0,1,2,4. `RegWr`=1 only in WB with RegDst=01, ALUOp=000. `instr_done` at cycle 4.
- IMEM_WAIT=2, DMEM_WAIT=3, LW: FETCH 3 cycles, MEM 4 cycles with `MemRd`=1. WB `RegWr`=1, Mem2Reg=01, EXTOp=01. Total 10 cycles.
- BEQ with NFlag=32'b10: EXEC `PCWr`=1, NPCSel=01. Same instruction with NFlag=0: `PCWr`=0, NPCSel=01, return to FETCH. 3 cycles each.
- ADDI with NFlag=32'b01: WB `RegWr`=0 and FlagOp=1. Same with NFlag=0: `RegWr`=1. ADDIU with NFlag=32'b01: `RegWr`=1.
- JAL: DECODE `PCWr`=1, `RegWr`=1, RegDst=10, Mem2Reg=10, NPCSel=10. 2 cycles. Opcode 111111 gives `illegal` pulse, no strobes, then FETCH.
- `rst_n` low during the SW MEM cycle (DMEM_WAIT=3): `MemWr` drops to 0 asynchronously, and state=0 after release.

Source files
------------

// File: rtl/mc_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mc_controller
//  Description : Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with
//                parametrised instruction/data memory wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_controller #(
    parameter int IMEM_WAIT = 0,
    parameter int DMEM_WAIT = 0,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] NFlag,
    output logic [1:0]  RegDst,
    output logic        ALUSrc,
    output logic [1:0]  Mem2Reg,
    output logic [1:0]  EXTOp,
    output logic [2:0]  ALUOp,
    output logic [1:0]  NPCSel,
    output logic        FlagOp,
    output logic        RegWr,
    output logic        MemWr,
    output logic        MemRd,
    output logic        PCWr,
    output logic        IRWr,
    output logic        illegal,
    output logic        instr_done,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [3:0] C_ADDU  = 4'd0;
    localparam logic [3:0] C_SUBU  = 4'd1;
    localparam logic [3:0] C_SLT   = 4'd2;
    localparam logic [3:0] C_JR    = 4'd3;
    localparam logic [3:0] C_ORI   = 4'd4;
    localparam logic [3:0] C_LW    = 4'd5;
    localparam logic [3:0] C_SW    = 4'd6;
    localparam logic [3:0] C_BEQ   = 4'd7;
    localparam logic [3:0] C_LUI   = 4'd8;
    localparam logic [3:0] C_J     = 4'd9;
    localparam logic [3:0] C_ADDI  = 4'd10;
    localparam logic [3:0] C_ADDIU = 4'd11;
    localparam logic [3:0] C_JAL   = 4'd12;
    localparam logic [3:0] C_ILL   = 4'd15;

    localparam logic [CNT_W-1:0] C_IMEM_LAST = CNT_W'(IMEM_WAIT);
    localparam logic [CNT_W-1:0] C_DMEM_LAST = CNT_W'(DMEM_WAIT);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;

    logic [3:0] w_cls;
    logic [1:0] w_regdst, w_mem2reg, w_extop, w_npcsel;
    logic       w_alusrc, w_flagop;
    logic [2:0] w_aluop;
    logic       w_unused_flags;

    assign w_unused_flags = ^NFlag[31:2];

    always_comb begin
        w_cls = C_ILL;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100001: w_cls = C_ADDU;
                    6'b100011: w_cls = C_SUBU;
                    6'b101010: w_cls = C_SLT;
                    6'b001000: w_cls = C_JR;
                    default:   w_cls = C_ILL;
                endcase
            end
            6'b001101: w_cls = C_ORI;
            6'b100011: w_cls = C_LW;
            6'b101011: w_cls = C_SW;
            6'b000100: w_cls = C_BEQ;
            6'b001111: w_cls = C_LUI;
            6'b000010: w_cls = C_J;
            6'b001000: w_cls = C_ADDI;
            6'b001001: w_cls = C_ADDIU;
            6'b000011: w_cls = C_JAL;
            default:   w_cls = C_ILL;
        endcase
    end

    // Per-class datapath selects; stable for the whole instruction since IR is.
    always_comb begin
        w_regdst  = 2'b00;
        w_alusrc  = 1'b0;
        w_mem2reg = 2'b00;
        w_extop   = 2'b00;
        w_aluop   = 3'b000;
        w_npcsel  = 2'b00;
        w_flagop  = 1'b0;
        case (w_cls)
            C_ADDU:  w_regdst = 2'b01;
            C_SUBU:  begin w_regdst = 2'b01; w_aluop = 3'b001; end
            C_SLT:   begin w_regdst = 2'b01; w_aluop = 3'b100; end
            C_ORI:   begin w_alusrc = 1'b1; w_aluop = 3'b011; end
            C_LUI:   begin w_alusrc = 1'b1; w_extop = 2'b10; w_aluop = 3'b011; end
            C_ADDI:  begin w_alusrc = 1'b1; w_extop = 2'b01; w_flagop = 1'b1; end
            C_ADDIU: begin w_alusrc = 1'b1; w_extop = 2'b01; end
            C_LW:    begin w_alusrc = 1'b1; w_extop = 2'b01; w_mem2reg = 2'b01; end
            C_SW:    begin w_alusrc = 1'b1; w_extop = 2'b01; end
            C_BEQ:   begin w_aluop = 3'b001; w_npcsel = 2'b01; end
            C_JR:    begin w_aluop = 3'b101; w_npcsel = 2'b11; end
            C_J:     w_npcsel = 2'b10;
            C_JAL:   begin
                w_regdst  = 2'b10;
                w_mem2reg = 2'b10;
                w_aluop   = 3'b101;
                w_npcsel  = 2'b10;
            end
            default: w_npcsel = 2'b00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        RegDst     = 2'b00;
        ALUSrc     = 1'b0;
        Mem2Reg    = 2'b00;
        EXTOp      = 2'b00;
        ALUOp      = 3'b000;
        NPCSel     = 2'b00;
        FlagOp     = 1'b0;
        RegWr      = 1'b0;
        MemWr      = 1'b0;
        MemRd      = 1'b0;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;

        if (run_q && state_q != S_FETCH) begin
            RegDst  = w_regdst;
            ALUSrc  = w_alusrc;
            Mem2Reg = w_mem2reg;
            EXTOp   = w_extop;
            ALUOp   = w_aluop;
            NPCSel  = w_npcsel;
            FlagOp  = w_flagop;
        end

        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    MemRd = 1'b1;
                    if (cnt_q == C_IMEM_LAST) begin
                        IRWr    = 1'b1;
                        PCWr    = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (w_cls)
                        C_J, C_JAL: begin
                            PCWr       = 1'b1;
                            RegWr      = (w_cls == C_JAL);
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        C_ILL: begin
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        default: state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (w_cls)
                        C_BEQ, C_JR: begin
                            PCWr       = (w_cls == C_JR) | NFlag[1];
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        C_LW, C_SW: state_d = S_MEM;
                        default:    state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    MemRd = (w_cls == C_LW);
                    MemWr = (w_cls == C_SW);
                    if (cnt_q == C_DMEM_LAST) begin
                        if (w_cls == C_SW) begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    RegWr      = ~(w_flagop & NFlag[0]);
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end

        // Counter restarts on every state change so FETCH/MEM begin at zero.
        if (!run_q || state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // run_q delays the first FETCH cycle to the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire
